// File: rtl/sd_cmd_if.sv
// Command/response handshake between the microSD command-builder FSM and the CMD-line PHY.
interface sd_cmd_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [5:0]  cmd_index;
  logic [31:0] cmd_arg;
  logic        resp_expect;
  logic        resp_valid;
  logic [47:0] resp_data;
  logic        resp_crc_ok;
  logic        resp_timeout;

  modport master (
    output cmd_valid, cmd_index, cmd_arg, resp_expect,
    input  cmd_ready, resp_valid, resp_data, resp_crc_ok, resp_timeout
  );

  modport slave (
    input  cmd_valid, cmd_index, cmd_arg, resp_expect,
    output cmd_ready, resp_valid, resp_data, resp_crc_ok, resp_timeout
  );
endinterface

// File: rtl/sd_cmd_phy.sv
// SD/SDIO CMD-line PHY: generates sdio_clk, serializes 48-bit host frames with CRC7,
// and captures the card's 48-bit response or reports a response timeout.
module sd_cmd_phy #(
  parameter int CLK_DIV      = 64,
  parameter int INIT_CLKS    = 80,
  parameter int RESP_TIMEOUT = 64,
  parameter int NRC_CLKS     = 8
) (
  input  logic     clk,
  input  logic     rst,
  sd_cmd_if.slave  bus,
  output logic     sdio_clk,
  output logic     sdio_cmd_o,
  output logic     sdio_cmd_oe,
  input  logic     sdio_cmd_i
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int CNT_W = 16;
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(INIT_CLKS - 1);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(RESP_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] NRC_LAST  = CNT_W'(NRC_CLKS - 1);

  typedef enum logic [2:0] {S_INIT, S_IDLE, S_SEND, S_WAIT, S_RECV, S_GAP} state_t;

  function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
    logic fb;
    fb = b ^ c[6];
    return {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
  endfunction

  function automatic logic [6:0] crc7_calc(input logic [39:0] d);
    logic [6:0] c;
    c = '0;
    for (int i = 39; i >= 0; i--) c = crc7_step(c, d[i]);
    return c;
  endfunction

  state_t           state, state_n;
  logic [DIV_W-1:0] div_cnt;
  logic [CNT_W-1:0] cnt;
  logic             tick, rise_tick, fall_tick, cnt_step;
  logic             accept, capture_done, timeout_hit;
  logic [39:0]      tx_sr;
  logic [6:0]       crc;
  logic             exp_q, tx_bit;
  logic [46:0]      rx_sr;
  logic [47:0]      rx_frame;
  logic             rx_crc_ok;

  assign tick      = (div_cnt == DIV_LAST);
  assign rise_tick = tick & ~sdio_clk;
  assign fall_tick = tick & sdio_clk;
  // SEND paces on falling edges; every other state counts rising edges.
  assign cnt_step  = (state == S_SEND) ? fall_tick : rise_tick;
  assign tx_bit    = (cnt < CNT_W'(40)) ? tx_sr[39] :
                     (cnt < CNT_W'(47)) ? crc[6]    : 1'b1;
  assign rx_frame  = {rx_sr, sdio_cmd_i};
  assign rx_crc_ok = (crc7_calc(rx_frame[47:8]) == rx_frame[7:1]);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt  <= '0;
      sdio_clk <= 1'b0;
    end else if (tick) begin
      div_cnt  <= '0;
      sdio_clk <= ~sdio_clk;
    end else begin
      div_cnt  <= div_cnt + 1'b1;
    end
  end

  always_comb begin
    state_n       = state;
    bus.cmd_ready = 1'b0;
    accept        = 1'b0;
    capture_done  = 1'b0;
    timeout_hit   = 1'b0;
    case (state)
      S_INIT: if (rise_tick && cnt == INIT_LAST) state_n = S_IDLE;
      S_IDLE: begin
        bus.cmd_ready = 1'b1;
        if (bus.cmd_valid) begin
          accept  = 1'b1;
          state_n = S_SEND;
        end
      end
      S_SEND: if (fall_tick && cnt == CNT_W'(47)) state_n = exp_q ? S_WAIT : S_GAP;
      S_WAIT: if (rise_tick) begin
        // A start bit wins over a simultaneous timeout.
        if (!sdio_cmd_i) state_n = S_RECV;
        else if (cnt == TO_LAST) begin
          timeout_hit = 1'b1;
          state_n     = S_GAP;
        end
      end
      S_RECV: if (rise_tick && cnt == CNT_W'(46)) begin
        capture_done = 1'b1;
        state_n      = S_GAP;
      end
      S_GAP:  if (rise_tick && cnt == NRC_LAST) state_n = S_IDLE;
      default: state_n = S_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state            <= S_INIT;
      cnt              <= '0;
      sdio_cmd_o       <= 1'b1;
      sdio_cmd_oe      <= 1'b0;
      bus.resp_valid   <= 1'b0;
      bus.resp_data    <= '0;
      bus.resp_crc_ok  <= 1'b0;
      bus.resp_timeout <= 1'b0;
    end else begin
      state          <= state_n;
      bus.resp_valid <= 1'b0;
      if (state_n != state) cnt <= '0;
      else if (cnt_step)    cnt <= cnt + 1'b1;
      case (state)
        S_INIT, S_IDLE: begin
          sdio_cmd_oe <= 1'b1;
          sdio_cmd_o  <= 1'b1;
        end
        S_SEND: if (fall_tick) sdio_cmd_o <= tx_bit;
        S_WAIT: if (fall_tick) sdio_cmd_oe <= 1'b0;
        S_GAP:  if (fall_tick) begin
          sdio_cmd_oe <= 1'b1;
          sdio_cmd_o  <= 1'b1;
        end
        default: ;
      endcase
      if (timeout_hit) begin
        bus.resp_valid   <= 1'b1;
        bus.resp_timeout <= 1'b1;
      end
      if (capture_done) begin
        bus.resp_valid   <= 1'b1;
        bus.resp_timeout <= 1'b0;
        bus.resp_data    <= rx_frame;
        bus.resp_crc_ok  <= rx_crc_ok;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      tx_sr <= {2'b01, bus.cmd_index, bus.cmd_arg};
      crc   <= '0;
      exp_q <= bus.resp_expect;
    end else if (state == S_SEND && fall_tick) begin
      if (cnt < CNT_W'(40)) begin
        tx_sr <= {tx_sr[38:0], 1'b0};
        crc   <= crc7_step(crc, tx_sr[39]);
      end else begin
        crc   <= {crc[5:0], 1'b0};
      end
    end
    if (rise_tick && (state == S_WAIT || state == S_RECV)) rx_sr <= {rx_sr[45:0], sdio_cmd_i};
  end

endmodule

// File: tb/tb_sd_cmd_phy.sv
// Bench for sd_cmd_phy: line-level card model plus a frame/timing reference model.
module tb_sd_cmd_phy;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic sdio_clk, sdio_cmd_o, sdio_cmd_oe, sdio_cmd_i;
  logic card_drv = 1'b1;

  sd_cmd_if bus();

  sd_cmd_phy #(.CLK_DIV(2), .INIT_CLKS(80), .RESP_TIMEOUT(64), .NRC_CLKS(8)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .sdio_clk(sdio_clk), .sdio_cmd_o(sdio_cmd_o), .sdio_cmd_oe(sdio_cmd_oe), .sdio_cmd_i(sdio_cmd_i)
  );

  assign sdio_cmd_i = sdio_cmd_oe ? sdio_cmd_o : card_drv;
  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;

  task automatic expect_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // CRC7 as the remainder of M(x)*x^7 divided by x^7+x^3+1.
  function automatic logic [6:0] ref_crc7(input logic [39:0] m);
    logic [46:0] r;
    r = {m, 7'b0};
    for (int i = 46; i >= 7; i--) if (r[i]) r = r ^ (47'h89 << (i - 7));
    return r[6:0];
  endfunction

  function automatic logic [47:0] host_frame(input logic [5:0] idx, input logic [31:0] arg);
    return {2'b01, idx, arg, ref_crc7({2'b01, idx, arg}), 1'b1};
  endfunction

  // Card configuration, written by the stimulus process only.
  bit          reply_en = 0;
  logic [47:0] reply_frame = '0;
  int          reply_delay = 1;

  // Line monitor / card state, written by the monitor process only.
  bit          sprev, rise, fall, tx_busy, card_arm, seen_ready, rdy_prev;
  int          rises, tx_bits, tx_done = 0, end_rise, evt_rise, rdy_rise, init_hi;
  int          card_fc, card_bit, rv_cnt = 0, rv_rise;
  logic [47:0] tx_sh, tx_frame = '0, rv_data;
  bit          rv_crc, rv_to;

  always @(negedge clk) begin
    if (!rst) begin
      sprev = 0; rises = 0; tx_busy = 0; card_arm = 0; card_drv = 1;
      seen_ready = 0; rdy_prev = 0; init_hi = 0; rdy_rise = 0;
    end else begin
      rise  = sdio_clk && !sprev;
      fall  = !sdio_clk && sprev;
      sprev = sdio_clk;
      if (rise) begin
        rises++;
        if (!seen_ready && sdio_cmd_oe && sdio_cmd_o) init_hi++;
      end
      if (bus.cmd_ready) seen_ready = 1;
      if (bus.cmd_ready && !rdy_prev) rdy_rise = rises;
      rdy_prev = bus.cmd_ready;
      if (fall) begin
        if (tx_busy) begin
          tx_sh = {tx_sh[46:0], sdio_cmd_o};
          tx_bits++;
          if (tx_bits == 48) begin
            tx_busy = 0; tx_frame = tx_sh; tx_done++;
            end_rise = rises; evt_rise = rises;
            card_arm = reply_en; card_fc = 0; card_bit = 0;
          end
        end else if (sdio_cmd_oe && !sdio_cmd_o) begin
          tx_busy = 1; tx_bits = 1; tx_sh = '0; card_arm = 0; card_drv = 1;
        end else if (card_arm) begin
          card_fc++;
          if (card_fc >= reply_delay) begin
            if (card_bit < 48) begin
              card_drv = reply_frame[47 - card_bit];
              card_bit++;
            end else begin
              card_drv = 1; card_arm = 0;
            end
          end
        end
      end
      if (bus.resp_valid) begin
        rv_cnt++; rv_data = bus.resp_data; rv_crc = bus.resp_crc_ok; rv_to = bus.resp_timeout;
        rv_rise = rises - end_rise; evt_rise = rises;
      end
    end
  end

  // Expected held response state.
  logic [47:0] model_data = '0;
  bit          model_crc = 0, model_to = 0;

  task automatic wait_ready(input string tag);
    int k = 0;
    while (!bus.cmd_ready && k < 20000) begin
      @(posedge clk); #1;
      k++;
    end
    expect_eq({tag, ".ready"}, bus.cmd_ready, 1'b1);
  endtask

  task automatic send_req(input logic [5:0] idx, input logic [31:0] arg, input bit rexp);
    bus.cmd_index = idx; bus.cmd_arg = arg; bus.resp_expect = rexp; bus.cmd_valid = 1'b1;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic do_cmd(input logic [5:0] idx, input logic [31:0] arg, input bit rexp,
                        input bit en, input logic [47:0] rf, input int dly, input string tag);
    int rv0, tx0, k;
    bit cap;
    reply_en = rexp && en; reply_frame = rf; reply_delay = dly;
    wait_ready(tag);
    rv0 = rv_cnt; tx0 = tx_done;
    send_req(idx, arg, rexp);
    expect_eq({tag, ".rdy_drop"}, bus.cmd_ready, 1'b0);
    k = 0;
    while (tx_done == tx0 && k < 2000) begin
      @(posedge clk); #1;
      k++;
    end
    expect_eq({tag, ".frame"}, tx_frame, host_frame(idx, arg));
    wait_ready(tag);
    @(negedge clk); #1;
    expect_eq({tag, ".nvalid"}, rv_cnt - rv0, rexp ? 1 : 0);
    expect_eq({tag, ".gap"}, rdy_rise - evt_rise, 8);
    if (rexp) begin
      cap = en && (dly <= 63);
      if (cap) begin
        model_data = rf; model_crc = (ref_crc7(rf[47:8]) == rf[7:1]); model_to = 0;
      end else begin
        model_to = 1;
      end
      expect_eq({tag, ".lat"}, rv_rise, cap ? dly + 48 : 64);
      expect_eq({tag, ".data"}, rv_data, model_data);
      expect_eq({tag, ".crc_ok"}, rv_crc, model_crc);
      expect_eq({tag, ".timeout"}, rv_to, model_to);
    end
    expect_eq({tag, ".hold"}, bus.resp_data, model_data);
    expect_eq({tag, ".hold_to"}, bus.resp_timeout, model_to);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [39:0] body;
    logic [47:0] rf;
    int mode, k;
    bus.cmd_valid = 1'b0; bus.cmd_index = '0; bus.cmd_arg = '0; bus.resp_expect = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    expect_eq("rst.sdio_clk", sdio_clk, 1'b0);
    expect_eq("rst.cmd_o", sdio_cmd_o, 1'b1);
    expect_eq("rst.oe", sdio_cmd_oe, 1'b0);
    expect_eq("rst.ready", bus.cmd_ready, 1'b0);
    expect_eq("rst.rv", bus.resp_valid, 1'b0);
    expect_eq("rst.data", bus.resp_data, 48'h0);
    expect_eq("rst.crc", bus.resp_crc_ok, 1'b0);
    expect_eq("rst.to", bus.resp_timeout, 1'b0);
    rst = 1'b1;

    wait_ready("init");
    @(negedge clk); #1;
    expect_eq("init.high_rises", init_hi, 80);
    expect_eq("init.ready_rise", rdy_rise, 80);
    expect_eq("init.no_rv", rv_cnt, 0);

    do_cmd(6'd0, 32'h0, 1'b0, 1'b0, 48'h0, 1, "cmd0");
    expect_eq("cmd0.const", tx_frame, 48'h400000000095);

    rf = {40'h08000001AA, ref_crc7(40'h08000001AA), 1'b1};
    do_cmd(6'd8, 32'h000001AA, 1'b1, 1'b1, rf, 5, "cmd8");
    expect_eq("cmd8.const", tx_frame, 48'h48000001AA87);

    do_cmd(6'd5, 32'h00200000, 1'b1, 1'b0, 48'h0, 1, "cmd5_to");
    do_cmd(6'd8, 32'h000001AA, 1'b1, 1'b1, rf ^ (48'h1 << 20), 5, "cmd8_flip");
    do_cmd(6'd8, 32'h000001AA, 1'b1, 1'b1, rf, 63, "start_at_limit");
    do_cmd(6'd8, 32'h000001AA, 1'b1, 1'b1, rf, 64, "start_late");
    do_cmd(6'd55, 32'h12345678, 1'b1, 1'b1, 48'h0, 3, "stuck0");

    for (int i = 0; i < 12; i++) begin
      body = {2'b00, 6'($urandom), 32'($urandom)};
      rf   = {body, ref_crc7(body), 1'b1};
      mode = $urandom_range(0, 3);
      if (mode == 2) rf = rf ^ (48'h1 << $urandom_range(8, 45));
      do_cmd(6'($urandom), 32'($urandom), mode != 0, mode != 3, rf,
             $urandom_range(1, 70), $sformatf("rnd%0d", i));
    end

    wait_ready("rst6.pre");
    send_req(6'd17, 32'hDEADBEEF, 1'b0);
    k = 0;
    while (!(tx_busy && tx_bits >= 20) && k < 2000) begin
      @(posedge clk); #1;
      k++;
    end
    expect_eq("rst6.reach_bit20", tx_busy && tx_bits >= 20, 1'b1);
    rst = 1'b0;
    #1;
    expect_eq("rst6.oe", sdio_cmd_oe, 1'b0);
    expect_eq("rst6.cmd_o", sdio_cmd_o, 1'b1);
    expect_eq("rst6.ready", bus.cmd_ready, 1'b0);
    expect_eq("rst6.data", bus.resp_data, 48'h0);
    model_data = '0; model_crc = 0; model_to = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    wait_ready("rst6.init");
    @(negedge clk); #1;
    expect_eq("rst6.high_rises", init_hi, 80);
    expect_eq("rst6.ready_rise", rdy_rise, 80);
    do_cmd(6'd0, 32'h0, 1'b0, 1'b0, 48'h0, 1, "rst6.cmd0");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
